seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised time-multiplexed 7-segment driver. It generalises the fixed 4-digit minutes/seconds display to N digits.
- Features:
  - full hex decode
  - per-digit decimal point
  - leading-zero blanking
  - per-digit blink
  - optional anode guard slot against ghosting
  - frame-wrap strobe
- Sits between the stopwatch counters/clock-enable divider and the board segment/anode pins.
- Registered outputs. Segments and anode are always aligned to the same digit.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- GUARD, 0: 1 inserts one all-off tick before every digit slot; 0 means no guard.
- BLINK_FRAMES, 64: number of complete scan frames per blink half-period; must be at least 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- clk_en  input  1  scan tick; state advances only on clk edges where clk_en=1.
- digits  input  4*NUM_DIGITS  hex value per digit; digit k = digits[4k+3:4k]; digit 0 is rightmost.
- dp  input  NUM_DIGITS  decimal point request per digit, active high.
- blink_mask  input  NUM_DIGITS  1 = digit blinks.
- blank_lz  input  1  1 = suppress leading zeros.
- display_seg  output  8  active-low segments; [0]=a .. [6]=g, [7]=dp.
- an  output  NUM_DIGITS  active-low anodes; an[k] drives digit k.
- scan_wrap  output  1  one-clk pulse at the start of each frame.

Behaviour:
- Reset (synchronous, overrides clk_en):
  - an = all ones; display_seg = 8'hFF; scan_wrap = 0.
  - Digit index = NUM_DIGITS-1; guard phase = first slot; blink phase = 0 (visible); frame counter = 0.
  - Reset mid-frame restarts the scan from digit NUM_DIGITS-1 on the next tick.
- clk_en=0: all state and outputs hold, except scan_wrap, which is 0.
- Scan order is NUM_DIGITS-1 down to 0, then wrap. Index counter width is $clog2(NUM_DIGITS).
- GUARD=0: each tick loads digit idx.
  - an = one-hot low at idx.
  - display_seg decoded from the digits and dp values sampled at that edge.
  - idx then decrements, or wraps to NUM_DIGITS-1 after 0.
  - Frame = NUM_DIGITS ticks.
- GUARD=1: two-state FSM per digit, GUARD_SLOT then SHOW.
  - GUARD_SLOT tick drives an = all ones, display_seg = 8'hFF.
  - SHOW tick loads the digit as above.
  - Frame = 2*NUM_DIGITS ticks.
- Latency: one clk from a sampling tick to the pins. There is no extra pipeline lag between anode and segments.
- Decode, active-low {g,f,e,d,c,b,a}:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:18, A:08, b:03, C:46, d:21, E:06, F:0E
  - display_seg[7] = ~dp[k].
- Leading-zero blank: digit k (k != 0) is blanked when blank_lz=1 and every digit from NUM_DIGITS-1 down to k is 0. Digit 0 is never lz-blanked.
- Blink:
  - Frame counter increments on the tick that loads digit 0. On reaching BLINK_FRAMES-1 it clears and toggles the blink phase.
  - While the blink phase is 1, digits with blink_mask[k]=1 are blanked.
- Blanked digit slot: an = all ones, display_seg = 8'hFF, including dp. The slot still consumes its tick.
- scan_wrap = 1 for exactly one clk, on the same edge that loads digit NUM_DIGITS-1. This includes the first load after reset.
- Inputs may change on any clk. They are used only at the tick that loads the digit.

Test Plan:
Common setup: NUM_DIGITS=4, GUARD=0, BLINK_FRAMES=2, clk_en=1 every clk unless stated.
- Reset: rst=1 for 3 clks with clk_en=1 → an=4'b1111, display_seg=8'hFF, scan_wrap=0. First tick after release → an=4'b0111 and scan_wrap=1.
- Normal scan: digits=16'h1234, dp=4'b0100 → ticks produce, in order:
  - an=0111, seg=8'hF9
  - an=1011, seg=8'h24 (dp on)
  - an=1101, seg=8'hB0
  - an=1110, seg=8'h99
  - then repeats with scan_wrap=1.
- Hex and lz: digits=16'h00AF, blank_lz=1 → digits 3 and 2 give an=1111/seg=FF; digit 1 gives 8'h88; digit 0 gives 8'h8E. digits=16'h0000 → only digit 0 shows 8'hC0.
- Blink: digits=16'h1234, blink_mask=4'b0001 → digit 0 shows 8'h99 in frames 0-1, is blank (an=1111, seg=FF) in frames 2-3, and is visible again in frame 4. Digits 3..1 are unaffected.
- Guard: GUARD=1, digits=16'h8888 → ticks alternate an=1111/seg=FF and the one-hot anode with seg=8'h80. scan_wrap period is 8 ticks.
- Hold/reset mid-frame: hold clk_en=0 for 10 clks during the digit-2 slot → outputs unchanged, scan_wrap=0. Then assert rst for 1 clk → reset values; next tick shows digit 3 with scan_wrap=1.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit 7-segment driver: hex decode, dp, leading-zero blank, blink, optional guard slot.
// Latency: one clk from the sampling tick to the pins; no backpressure, state advances only on clk_en.
module seg_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int GUARD        = 0,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    output logic [7:0]              display_seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    scan_wrap
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(BLINK_FRAMES - 1);

    typedef enum logic {
        GUARD_SLOT = 1'b0,
        SHOW       = 1'b1
    } state_t;

    // Without a guard the FSM simply sits in SHOW forever.
    localparam state_t FIRST_SLOT = (GUARD != 0) ? GUARD_SLOT : SHOW;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [FC_W-1:0]         frame_cnt, frame_cnt_nxt;
    logic                    blink_phase, blink_phase_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [7:0]              seg_nxt;
    logic                    wrap_nxt;
    logic [3:0]              nib;
    logic                    lz_hit;
    logic                    blink_hit;

    always_comb begin
        nib       = 4'(digits >> (4 * int'(idx)));
        // Shifting out the lower digits leaves exactly digits idx..N-1 to test for zero.
        lz_hit    = blank_lz && (idx != '0) && ((digits >> (4 * int'(idx))) == '0);
        blink_hit = blink_phase && blink_mask[idx];

        state_nxt       = state;
        idx_nxt         = idx;
        frame_cnt_nxt   = frame_cnt;
        blink_phase_nxt = blink_phase;
        an_nxt          = an;
        seg_nxt         = display_seg;
        wrap_nxt        = 1'b0;

        if (clk_en) begin
            if (state == GUARD_SLOT) begin
                an_nxt    = '1;
                seg_nxt   = 8'hFF;
                state_nxt = SHOW;
            end else begin
                state_nxt = FIRST_SLOT;
                wrap_nxt  = (idx == IDX_TOP);
                if (lz_hit || blink_hit) begin
                    an_nxt  = '1;
                    seg_nxt = 8'hFF;
                end else begin
                    an_nxt  = ~(NUM_DIGITS'(1) << idx);
                    seg_nxt = {~dp[idx], hex_decode(nib)};
                end
                if (idx == '0) begin
                    idx_nxt = IDX_TOP;
                    if (frame_cnt == FC_LAST) begin
                        frame_cnt_nxt   = '0;
                        blink_phase_nxt = ~blink_phase;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FIRST_SLOT;
            idx         <= IDX_TOP;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            an          <= '1;
            display_seg <= 8'hFF;
            scan_wrap   <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            frame_cnt   <= frame_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            an          <= an_nxt;
            display_seg <= seg_nxt;
            scan_wrap   <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: a no-guard and a guard instance share stimulus and are compared to a slot-position model.
module tb_seg_scan_display;

    localparam int N  = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic [7:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic        wrap0, wrap1;

    always #5 clk = ~clk;

    seg_scan_display #(.NUM_DIGITS(N), .GUARD(0), .BLINK_FRAMES(BF)) dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .digits(digits), .dp(dp),
        .blink_mask(blink_mask), .blank_lz(blank_lz),
        .display_seg(seg0), .an(an0), .scan_wrap(wrap0)
    );

    seg_scan_display #(.NUM_DIGITS(N), .GUARD(1), .BLINK_FRAMES(BF)) dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .digits(digits), .dp(dp),
        .blink_mask(blink_mask), .blank_lz(blank_lz),
        .display_seg(seg1), .an(an1), .scan_wrap(wrap1)
    );

    logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;
    logic [3:0] ea0, ea1;
    logic [7:0] es0, es1;
    logic       ew0, ew1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (tick %0d)", tag, obs, exp, t);
    endtask

    // Expected pins for enabled tick number tt since reset, from slot position and frame number.
    task automatic model(input int g, input int tt, output logic [3:0] a,
                         output logic [7:0] s, output logic w);
        int slots, p, f, d;
        logic lz, bl;
        slots = g ? 2 * N : N;
        p = tt % slots;
        f = tt / slots;
        a = 4'hF;
        s = 8'hFF;
        w = 1'b0;
        if (g && (p % 2 == 0)) return;
        d  = N - 1 - (g ? p / 2 : p);
        w  = (d == N - 1);
        lz = blank_lz && (d != 0);
        for (int j = d; j < N; j++)
            if (digits[4*j +: 4] != 4'h0) lz = 1'b0;
        bl = ((f / BF) % 2 == 1) && blink_mask[d];
        if (!(lz || bl)) begin
            a = 4'hF & ~(4'h1 << d);
            s = {~dp[d], hex7[digits[4*d +: 4]]};
        end
    endtask

    task automatic step(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
        if (rst) begin
            t = 0;
            ea0 = 4'hF; es0 = 8'hFF; ew0 = 1'b0;
            ea1 = 4'hF; es1 = 8'hFF; ew1 = 1'b0;
        end else if (en) begin
            model(0, t, ea0, es0, ew0);
            model(1, t, ea1, es1, ew1);
            t++;
        end else begin
            ew0 = 1'b0;
            ew1 = 1'b0;
        end
        check("an_g0", an0, ea0);
        check("seg_g0", seg0, es0);
        check("wrap_g0", wrap0, ew0);
        check("an_g1", an1, ea1);
        check("seg_g1", seg1, es1);
        check("wrap_g1", wrap1, ew1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
    endtask

    logic [3:0] scan_an  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [7:0] scan_seg [4] = '{8'hF9, 8'h24, 8'hB0, 8'h99};
    logic [7:0] lz_seg   [4] = '{8'hFF, 8'hFF, 8'h88, 8'h8E};
    logic [7:0] z_seg    [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hC0};

    initial begin
        rst = 1'b1; clk_en = 1'b1; digits = 16'h0; dp = 4'h0;
        blink_mask = 4'h0; blank_lz = 1'b0;

        // Reset held for three enabled clocks.
        for (int i = 0; i < 3; i++) step(1'b1);
        check("rst_an", an0, 4'b1111);
        check("rst_seg", seg0, 8'hFF);
        check("rst_wrap", wrap0, 1'b0);
        rst = 1'b0;

        // Normal scan of 1234 with dp on digit 2, two frames.
        digits = 16'h1234; dp = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("scan_an", an0, scan_an[i % 4]);
            check("scan_seg", seg0, scan_seg[i % 4]);
            check("scan_wrap", wrap0, (i % 4 == 0));
        end

        // Hex decode with leading-zero blanking.
        digits = 16'h00AF; dp = 4'h0; blank_lz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            check("lz_seg", seg0, lz_seg[i]);
        end
        digits = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            check("zero_seg", seg0, z_seg[i]);
        end

        // Blink on digit 0 over five frames.
        blank_lz = 1'b0; digits = 16'h1234; blink_mask = 4'b0001;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            if (i % 4 == 3)
                check("blink_seg", seg0, ((i / 4 == 2) || (i / 4 == 3)) ? 8'hFF : 8'h99);
            else
                check("blink_other", seg0, scan_seg[i % 4] | 8'h80);
        end

        // Guard slots on the GUARD=1 instance.
        digits = 16'h8888; blink_mask = 4'h0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1);
            if (i % 2 == 0) begin
                check("guard_an", an1, 4'hF);
                check("guard_seg", seg1, 8'hFF);
            end else begin
                check("guard_show_an", an1, scan_an[(i / 2) % 4]);
                check("guard_show_seg", seg1, 8'h80);
            end
            check("guard_wrap", wrap1, (i % 8 == 1));
        end

        // Hold during the digit-2 slot, then reset mid-frame.
        digits = 16'h1234; dp = 4'b0100;
        do_reset();
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check("hold_an", an0, 4'b1011);
            check("hold_seg", seg0, 8'h24);
        end
        do_reset();
        step(1'b1);
        check("restart_an", an0, 4'b0111);
        check("restart_wrap", wrap0, 1'b1);

        // Randomized inputs, enable gaps and occasional resets.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < N; k++)
                digits[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            dp         = 4'($urandom);
            blink_mask = 4'($urandom);
            blank_lz   = 1'($urandom);
            rst        = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
